// File: rtl/cache_arbiter_pkg.sv
// ============================================================================
// Module   : arb_types (package)
// Purpose  : Shared state/source enums and default sizes for cache_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_types;

  localparam int c_line_width  = 256;
  localparam int c_offset_bits = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    TURN    = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

endpackage

`default_nettype wire

// File: rtl/cache_arbiter_grant_select.sv
// ============================================================================
// Module   : arb_grant_select
// Purpose  : Combinational winner choice between I-cache and D-cache requests.
//            ARB_ROUND_ROBIN_EN selects alternating tie-break instead of D-first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_grant_select
  import arb_types::*;
(
  input  logic     i_req_i,
  input  logic     i_req_d,
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_src_t i_last_grant,
`endif
  output logic     o_any,
  output arb_src_t o_grant
);

  always_comb begin
    o_any   = i_req_i | i_req_d;
    o_grant = SRC_I;
    if (i_req_i && i_req_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      o_grant = (i_last_grant == SRC_I) ? SRC_D : SRC_I;
`else
      o_grant = SRC_D;
`endif
    end else if (i_req_d) begin
      o_grant = SRC_D;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ============================================================================
// Module   : cache_arbiter
// Purpose  : Shares one physical-memory port between the L1 I- and D-caches.
//            Optional macro ARB_ROUND_ROBIN_EN enables round-robin tie-break.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter
  import arb_types::*;
#(
  parameter int LINE_WIDTH  = c_line_width,
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = c_offset_bits
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_addr,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam logic [ADDR_WIDTH-1:0] c_off_mask =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic                  r_op_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  w_any;
  arb_src_t              w_grant;
  logic                  w_grant_now;

`ifdef ARB_ROUND_ROBIN_EN
  arb_src_t              r_last_grant;
`endif

  arb_grant_select u_grant_select (
    .i_req_i      (i_read),
    .i_req_d      (d_read | d_write),
`ifdef ARB_ROUND_ROBIN_EN
    .i_last_grant (r_last_grant),
`endif
    .o_any        (w_any),
    .o_grant      (w_grant)
  );

  assign w_grant_now = (r_state == IDLE) && w_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_op_write   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_grant <= SRC_I;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_grant_now) begin
        r_addr     <= ((w_grant == SRC_D) ? d_addr : i_addr) & c_off_mask;
        r_wdata    <= d_wdata;
        // A simultaneous read+write from the D-cache is served as the write-back.
        r_op_write <= (w_grant == SRC_D) && d_write;
`ifdef ARB_ROUND_ROBIN_EN
        r_last_grant <= w_grant;
`endif
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next_state = (w_grant == SRC_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_resp       = 1'b1;
          w_next_state = TURN;
        end
      end
      SERVE_D: begin
        pmem_read  = ~r_op_write;
        pmem_write = r_op_write;
        if (pmem_resp) begin
          d_resp       = 1'b1;
          w_next_state = TURN;
        end
      end
      TURN:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign i_rdata    = pmem_rdata;
  assign d_rdata    = pmem_rdata;
  assign pmem_addr  = r_addr;
  assign pmem_wdata = r_wdata;

endmodule

`default_nettype wire
